// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction FIFO with a registered head entry (zero when empty).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  fetch_entry_t  wdata_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic          head_valid_o,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] occ_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          head_valid_q, head_valid_d;
    fetch_entry_t  head_q, head_d;
    logic          do_pop;

    // Next pointers/occupancy and the head entry as seen after this edge.
    always_comb begin
        do_pop       = pop_i && (occ_q != '0);
        rd_d         = rd_q;
        wr_d         = wr_q;
        occ_d        = occ_q;
        head_valid_d = 1'b0;
        head_d       = '0;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            occ_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (do_pop) rd_d = rd_q + PW'(1);
            occ_d = occ_q + CW'(push_i) - CW'(do_pop);
            if (occ_d != '0) begin
                head_valid_d = 1'b1;
                // The word being written becomes head when nothing older remains.
                head_d = (push_i && (occ_q == CW'(do_pop))) ? wdata_i : mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q         <= '0;
            wr_q         <= '0;
            occ_q        <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            occ_q        <= occ_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;
    assign occ_o        = occ_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC ownership, imem request/response, fetch FIFO, redirect flush.
// Optional FETCH_QUEUE_PERF_EN adds stall/flush performance counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    input  logic        id_ready
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned SW = CW + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic          req_q, req_d;
    logic          fire, rsp, pop, push, clear;
    logic [CW-1:0] occ, occ_next;
    logic [31:0]   target_pc, rsp_pc;
    fetch_entry_t  push_entry, head;
    logic          head_valid;

    assign target_pc = redirect_pc & ~32'd3;
    // Registered request is masked while a redirect is present so the stale PC is never granted.
    assign imem_req  = req_q && !redirect;
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;
    assign rsp       = imem_rvalid && (out_q != '0);
    assign pop       = head_valid && id_ready;

    // Requests are sequential, so the oldest in-flight address trails pc by the outstanding count.
    assign rsp_pc     = pc_q - (32'(out_q) << 2);
    assign push_entry = '{instr: imem_rdata, pc4: rsp_pc + PC_STEP};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        clear   = 1'b0;
        out_d   = out_q + CW'(fire) - CW'(rsp);
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redirect) pc_d = target_pc;
            end
            RUN: begin
                if (redirect) begin
                    clear   = 1'b1;
                    pc_d    = target_pc;
                    state_d = (out_d == '0) ? RUN : FLUSH;
                end else begin
                    push = rsp;
                    if (fire) pc_d = pc_q + PC_STEP;
                end
            end
            FLUSH: begin
                if (redirect) pc_d = target_pc;
                if (out_d == '0) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
        occ_next = clear ? '0 : (occ + CW'(push) - CW'(pop));
        req_d    = (state_d == RUN) && ((SW'(occ_next) + SW'(out_d)) < SW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            req_q   <= req_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .wdata_i      (push_entry),
        .pop_i        (pop),
        .clear_i      (clear),
        .head_valid_o (head_valid),
        .head_o       (head),
        .occ_o        (occ)
    );

    assign id_valid = head_valid;
    assign id_instr = head.instr;
    assign id_pc4   = head.pc4;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Starved-decode cycles outside BOOT, and every redirect seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q != BOOT) && !head_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed phases then randomized traffic against a queue-based model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int NCYC = 2500;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_ready;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
    logic [31:0] m_stall;
    logic [15:0] m_flush;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_ready    (id_ready)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_rsp_t;

    int checks = 0;
    int errors = 0;
    int cyc;

    // Model: mode 0 boot, 1 run, 2 flush; fetched words; addresses in flight.
    int          m_mode;
    logic [31:0] m_pc;
    logic [63:0] m_fifo [$];
    logic [31:0] m_infl [$];
    mem_rsp_t    mq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    initial begin
        logic        e_req, e_valid, fire, rsp, seen_grant, seen_valid, directed;
        logic [63:0] e_entry;
        logic [31:0] a, tgt;
        int          lat;
        mem_rsp_t    r;

        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        seen_grant = 1'b0; seen_valid = 1'b0; lat = 1; cyc = -1;
        m_mode = 0; m_pc = 32'h0;
`ifdef FETCH_QUEUE_PERF_EN
        m_stall = '0; m_flush = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            directed = (cyc < 80);
            lat      = (cyc < 50) ? 1 : (directed ? 3 : $urandom_range(1, 4));
            imem_gnt = (cyc >= 45 && cyc <= 47) ? 1'b0 : (directed ? 1'b1 : ($urandom_range(0, 3) != 0));
            id_ready = (cyc >= 30 && cyc <= 39) ? 1'b0 : (directed ? 1'b1 : ($urandom_range(0, 9) < 7));
            if (cyc == 60) begin
                redirect = 1'b1; redirect_pc = 32'h0000_0100;
            end else if (directed) begin
                redirect = 1'b0; redirect_pc = $urandom;
            end else begin
                redirect    = ($urandom_range(0, 24) == 0);
                redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF5 : $urandom;
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mq[0].data;
                void'(mq.pop_front());
            end else begin
                imem_rvalid = !directed && ($urandom_range(0, 9) == 0);
                imem_rdata  = $urandom;
            end

            @(negedge clk);
            e_req   = (m_mode == 1) && ((m_fifo.size() + m_infl.size()) < DEPTH) && !redirect;
            e_valid = (m_fifo.size() != 0);
            e_entry = e_valid ? m_fifo[0] : 64'h0;
            chk("imem_req", 32'(imem_req), 32'(e_req));
            chk("imem_addr", imem_addr, m_pc);
            chk("id_valid", 32'(id_valid), 32'(e_valid));
            chk("id_instr", id_instr, e_entry[63:32]);
            chk("id_pc4", id_pc4, e_entry[31:0]);

            if (cyc == 0) chk("boot_req", 32'(imem_req), 32'h0);
            if (cyc == 1) begin
                chk("first_req", 32'(imem_req), 32'h1);
                chk("first_addr", imem_addr, 32'h0);
            end
            if (cyc == 2) chk("second_addr", imem_addr, 32'h4);
            if (cyc == 3) begin
                chk("first_valid", 32'(id_valid), 32'h1);
                chk("first_pc4", id_pc4, 32'h4);
                chk("first_instr", id_instr, 32'h0);
            end
            if (cyc == 4) chk("second_pc4", id_pc4, 32'h8);
            if (cyc == 39) begin
                chk("full_req", 32'(imem_req), 32'h0);
                chk("full_valid", 32'(id_valid), 32'h1);
                chk("full_model_occ", 32'(m_fifo.size()), 32'd4);
            end
            if (cyc > 60 && !seen_grant && imem_req && imem_gnt) begin
                seen_grant = 1'b1;
                chk("redir_first_addr", imem_addr, 32'h0000_0100);
            end
            if (cyc > 60 && !seen_valid && id_valid) begin
                seen_valid = 1'b1;
                chk("redir_first_pc4", id_pc4, 32'h0000_0104);
            end
            if (cyc == 79) chk("redir_seen", {30'h0, seen_grant, seen_valid}, 32'h3);

            // Advance the model by one clock using this cycle's inputs.
            fire = e_req && imem_gnt;
            rsp  = imem_rvalid && (m_infl.size() != 0);
            a    = '0;
            if (rsp) a = m_infl.pop_front();
            if (fire) begin
                r.data = directed ? m_pc : $urandom;
                r.due  = cyc + lat;
                mq.push_back(r);
            end
`ifdef FETCH_QUEUE_PERF_EN
            if (m_mode != 0 && !e_valid) m_stall = m_stall + 32'd1;
            if (redirect) m_flush = m_flush + 16'd1;
`endif
            tgt = {redirect_pc[31:2], 2'b00};
            if (m_mode == 0) begin
                m_mode = 1;
                if (redirect) m_pc = tgt;
            end else if (redirect) begin
                m_fifo.delete();
                m_pc   = tgt;
                m_mode = (m_infl.size() == 0) ? 1 : 2;
            end else if (m_mode == 1) begin
                if (e_valid && id_ready) void'(m_fifo.pop_front());
                if (rsp) m_fifo.push_back({imem_rdata, a + 32'd4});
                if (fire) begin
                    m_infl.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_infl.size() == 0) begin
                m_mode = 1;
            end

            @(posedge clk); #1;
        end

`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, m_stall);
        chk("perf_flush_cnt", 32'(perf_flush_cnt), 32'(m_flush));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the phase-3 pipelined MIPS32 core. It sits directly upstream of the decode/register-bank stage and replaces the single-cycle PC → SUMADOR → MEM_INST path. The block owns the PC, issues word requests to instruction memory over a request/grant plus response-valid handshake, and buffers returned words with their PC+4 in a small FIFO. It also handles taken-branch redirects from the Branch/MultiplexorPC logic by flushing the queue and discarding in-flight responses.

## Interface
- DEPTH, 4, FIFO entries; also the maximum number of outstanding memory requests (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (bits [1:0] always 0)
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  in-order response data valid
- imem_rdata  in  32  response instruction word
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  32  new fetch target (bits [1:0] ignored, forced 0)
- id_valid  out  1  queue head valid toward decode
- id_instr  out  32  queue head instruction; 32'h0 (NOP) when id_valid=0
- id_pc4  out  32  PC+4 of head instruction; 0 when id_valid=0
- id_ready  in  1  decode consumes head when id_valid=1

## Operation
- FSM states: BOOT, RUN, FLUSH.
- BOOT: entered on reset; imem_req=0; next cycle goes to RUN.
- RUN: imem_req=1 iff occ + outstanding < DEPTH and redirect=0. imem_addr=pc. On req&&gnt: pc ← pc+4 (modulo 2^32 wrap), outstanding+1.
- Response: on imem_rvalid with outstanding>0, outstanding−1. In RUN, push {imem_rdata, addr_of_response+4}; a response FIFO of issued PCs (or a tail-PC counter) tracks addresses. imem_rvalid with outstanding=0 is ignored.
- Pop: id_valid && id_ready removes head.
- Invariant occ + outstanding ≤ DEPTH, so a response never finds the FIFO full.
- Redirect (any state except BOOT): FIFO cleared, pop and response in the same cycle discarded, pc ← redirect_pc. If outstanding after this cycle's decrement is 0 → RUN, else → FLUSH.
- FLUSH: imem_req=0; all responses discarded while decrementing outstanding; when outstanding reaches 0 → RUN, issuing from the latched redirect_pc on the following cycle. Further redirect in FLUSH overwrites target, stays in FLUSH.
- Redirect in BOOT: pc ← redirect_pc, go to RUN.
- Push and pop in the same cycle: occ unchanged, FIFO order preserved.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc4=0, state=BOOT, occ=0, outstanding=0.
- First reset-high cycle is BOOT; first imem_req=1 one cycle later.
- Response accepted at edge k → id_valid=1 in cycle k+1 (no bypass).
- imem_addr/imem_req registered; must hold while imem_req=1 and imem_gnt=0 unless redirect occurs.
- Sustained throughput: 1 instruction/cycle with single-cycle memory and id_ready=1.
- Redirect at edge k → first request to redirect_pc in cycle k+1 (no in-flight) or one cycle after outstanding drains.

## Configuration
- FETCH_QUEUE_PERF_EN defined: adds outputs perf_stall_cnt (32, counts cycles id_valid=0 in RUN/FLUSH) and perf_flush_cnt (16, counts redirects), both reset to 0, wrapping.
- Undefined: those ports and counters do not exist; behaviour otherwise identical.

## Structure
- Shared package fetch_pkg: state enum (BOOT/RUN/FLUSH), NOP_INSTR=32'h0, PC_STEP=32'd4, width helper for clog2(DEPTH+1).
- One sub-module: fetch_fifo (DEPTH × 64-bit {instr, pc4}, push/pop/clear, occ output), instantiated once.

## Test plan
- Reset released, 1-cycle-latency memory returning addr as data, id_ready=1 → requests 0x0,0x4,0x8… back-to-back; id_pc4 = 0x4,0x8…; first id_valid 3 cycles after reset rises.
- id_ready=0 for 10 cycles → exactly DEPTH=4 requests issued, then imem_req=0; occ=4; resume → no word lost or duplicated.
- imem_gnt=0 for 3 cycles → imem_addr stable at 0x8, pc does not advance.
- Memory latency 3, two requests outstanding, redirect to 0x100 → FLUSH, both stale responses dropped, next request 0x100, id_valid=0 until 0x100 word arrives.
- redirect same cycle as rvalid and pop with occ=2 → occ=0, response dropped, next request redirect_pc.
- With FETCH_QUEUE_PERF_EN, 3 redirects and 5 starved cycles → perf_flush_cnt=3, perf_stall_cnt=5.
